// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and oversampling ratio.
package uart_pkg;
  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;
endpackage

// File: rtl/uart_tx_if.sv
// Byte write channel into the UART transmitter.
// A byte transfers on every clk edge where i_tx_valid and o_tx_ready are both high;
// o_tx_ready never depends on i_tx_valid, and i_tx_data is only meaningful while i_tx_valid is high.
interface uart_tx_if;
  logic       i_tx_valid;
  logic [7:0] i_tx_data;
  logic       o_tx_ready;

  modport master (output i_tx_valid, output i_tx_data, input o_tx_ready);
  modport slave  (input i_tx_valid, input i_tx_data, output o_tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding bytes waiting to be serialised.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent LSB-first as start, 8 data, optional parity, 1-2 stop bits,
// with every bit lasting OVERSAMPLE ticks of the shared 16x baud enable.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_clk_tx,
  uart_tx_if.slave  bus,
  output logic      o_txd,
  output logic      TxDone,
  output logic      o_busy,
  output tx_state_t dbg_state
);
  tx_state_t  state;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic       stop_cnt;
  logic [7:0] shreg;
  logic       par_bit;

  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       pop;
  logic       bit_end;

  assign bus.o_tx_ready = !fifo_full;
  assign pop            = (state == TX_IDLE) && !fifo_empty;
  assign bit_end        = i_clk_tx && (tick_cnt == 4'(OVERSAMPLE - 1));
  assign o_busy         = (state != TX_IDLE);
  assign dbg_state      = state;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.i_tx_valid && bus.o_tx_ready),
    .pop   (pop),
    .din   (bus.i_tx_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // o_txd is loaded alongside every state change so the line moves on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= TX_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      o_txd    <= 1'b1;
      TxDone   <= 1'b0;
    end else begin
      TxDone <= 1'b0;
      if (state != TX_IDLE && i_clk_tx) tick_cnt <= bit_end ? 4'd0 : tick_cnt + 4'd1;
      case (state)
        TX_IDLE: begin
          o_txd <= 1'b1;
          if (!fifo_empty) begin
            shreg    <= fifo_dout;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= (PARITY == PAR_ODD) ? ~^fifo_dout : ^fifo_dout;
            state    <= TX_START;
            o_txd    <= 1'b0;
          end
        end
        TX_START: begin
          if (bit_end) begin
            state <= TX_DATA;
            o_txd <= shreg[0];
          end
        end
        TX_DATA: begin
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              if (PARITY != PAR_NONE) begin
                state <= TX_PARITY;
                o_txd <= par_bit;
              end else begin
                state <= TX_STOP;
                o_txd <= 1'b1;
              end
            end else begin
              o_txd <= shreg[1];
            end
          end
        end
        TX_PARITY: begin
          if (bit_end) begin
            state <= TX_STOP;
            o_txd <= 1'b1;
          end
        end
        TX_STOP: begin
          o_txd <= 1'b1;
          if (bit_end) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state  <= TX_IDLE;
              TxDone <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= TX_IDLE;
          o_txd <= 1'b1;
        end
      endcase
    end
  end
endmodule
